pipeline_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. It drives the load enables of PC and IF/ID, the bubble select of the ID/EX register, and the ID-stage operand forwarding muxes that feed PA/PB. It detects load-use hazards and holds the front end while a multi-cycle multiply/divide occupies EX. Forwarding and stall decisions are combinational from the current state and inputs; only the FSM state and the busy counter are registered.

---
 rtl/pipeline_pkg.sv | 22 ++
 rtl/pipeline_hazard_ctrl_if.sv | 38 +++
 rtl/pipeline_hazard_ctrl_fwd_select.sv | 42 ++++
 rtl/pipeline_hazard_ctrl.sv | 110 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
package pipeline_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam int unsigned CTRL_W = 25;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // ID/EX control input as seen through the bubble mux.
    function automatic logic [CTRL_W-1:0] bubble_mux(input logic [CTRL_W-1:0] ctrl,
                                                     input logic              bubble);
        return bubble ? '0 : ctrl;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller signal bundle between the pipeline datapath and the controller.
interface pipeline_hazard_ctrl_if;

    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_rs_used;
    logic       id_rt_used;
    logic       id_is_muldiv;
    logic [4:0] ex_rd;
    logic [4:0] mem_rd;
    logic [4:0] wb_rd;
    logic       ex_regwrite;
    logic       mem_regwrite;
    logic       wb_regwrite;
    logic       ex_load;

    logic       pc_ld;
    logic       ifid_ld;
    logic       idex_bubble;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       muldiv_start;
    logic       muldiv_busy;

    // Datapath side: reports pipeline contents, consumes enables and selects.
    modport master (
        output id_rs, id_rt, id_rs_used, id_rt_used, id_is_muldiv,
        output ex_rd, mem_rd, wb_rd, ex_regwrite, mem_regwrite, wb_regwrite, ex_load,
        input  pc_ld, ifid_ld, idex_bubble, fwd_a, fwd_b, muldiv_start, muldiv_busy
    );

    modport slave (
        input  id_rs, id_rt, id_rs_used, id_rt_used, id_is_muldiv,
        input  ex_rd, mem_rd, wb_rd, ex_regwrite, mem_regwrite, wb_regwrite, ex_load,
        output pc_ld, ifid_ld, idex_bubble, fwd_a, fwd_b, muldiv_start, muldiv_busy
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Per-operand forwarding select: EX over MEM over WB over register file.
module fwd_select
    import pipeline_pkg::*;
(
    input  logic [4:0] operand,
    input  logic       used,
    input  logic [4:0] ex_rd,
    input  logic       ex_regwrite,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwrite,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwrite,
    input  logic       ex_load,
    output logic [1:0] sel,
    output logic       load_hit
);

    logic live;
    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    // $0 is hardwired, so it never needs a forwarded value.
    assign live    = used && (operand != 5'd0);
    assign ex_hit  = live && ex_regwrite && (ex_rd == operand);
    assign mem_hit = live && mem_regwrite && (mem_rd == operand);
    assign wb_hit  = live && wb_regwrite && (wb_rd == operand);

    always_comb begin
        sel      = FWD_RF;
        load_hit = ex_hit && ex_load;
        // A load in EX has no result yet; fall back to older stages.
        if (ex_hit && !ex_load) begin
            sel = FWD_EX;
        end else if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing: load-use stall, mult/div front-end hold and ID operand forwarding.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = 8,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  hz
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;

    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       load_hit_a;
    logic       load_hit_b;
    logic       load_use;

    fwd_select u_fwd_a (
        .operand      (hz.id_rs),
        .used         (hz.id_rs_used),
        .ex_rd        (hz.ex_rd),
        .ex_regwrite  (hz.ex_regwrite),
        .mem_rd       (hz.mem_rd),
        .mem_regwrite (hz.mem_regwrite),
        .wb_rd        (hz.wb_rd),
        .wb_regwrite  (hz.wb_regwrite),
        .ex_load      (hz.ex_load),
        .sel          (sel_a),
        .load_hit     (load_hit_a)
    );

    fwd_select u_fwd_b (
        .operand      (hz.id_rt),
        .used         (hz.id_rt_used),
        .ex_rd        (hz.ex_rd),
        .ex_regwrite  (hz.ex_regwrite),
        .mem_rd       (hz.mem_rd),
        .mem_regwrite (hz.mem_regwrite),
        .wb_rd        (hz.wb_rd),
        .wb_regwrite  (hz.wb_regwrite),
        .ex_load      (hz.ex_load),
        .sel          (sel_b),
        .load_hit     (load_hit_b)
    );

    assign load_use = load_hit_a || load_hit_b;

    // cnt counts remaining BUSY cycles; leave when the last one is reached.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (!load_use && hz.id_is_muldiv) begin
                        state_q <= ST_BUSY;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        hz.pc_ld        = 1'b1;
        hz.ifid_ld      = 1'b1;
        hz.idex_bubble  = 1'b0;
        hz.muldiv_start = 1'b0;
        hz.muldiv_busy  = 1'b0;
        hz.fwd_a        = sel_a;
        hz.fwd_b        = sel_b;
        if (reset) begin
            // Pipeline registers clear themselves; keep the bubble in and selects neutral.
            hz.idex_bubble = 1'b1;
            hz.fwd_a       = FWD_RF;
            hz.fwd_b       = FWD_RF;
        end else if (state_q == ST_BUSY) begin
            hz.pc_ld       = 1'b0;
            hz.ifid_ld     = 1'b0;
            hz.idex_bubble = 1'b1;
            hz.muldiv_busy = 1'b1;
        end else if (load_use) begin
            hz.pc_ld       = 1'b0;
            hz.ifid_ld     = 1'b0;
            hz.idex_bubble = 1'b1;
        end else if (hz.id_is_muldiv) begin
            hz.muldiv_start = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with an expected-output scoreboard.
module tb_pipeline_hazard_ctrl;
    import pipeline_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [8:0] exp_q[$];
    string      tag_q[$];

    pipeline_hazard_ctrl_if bus ();

    pipeline_hazard_ctrl #(
        .MULDIV_CYCLES (8),
        .CNT_W         (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (bus)
    );

    always #5 clk = ~clk;

    // {pc_ld, ifid_ld, idex_bubble, fwd_a, fwd_b, muldiv_start, muldiv_busy}
    function automatic logic [8:0] ex(input logic pc, input logic ifid, input logic bub,
                                      input logic [1:0] fa, input logic [1:0] fb,
                                      input logic st, input logic busy);
        return {pc, ifid, bub, fa, fb, st, busy};
    endfunction

    localparam logic [8:0] RUN_IDLE = 9'b110_00_00_0_0;
    localparam logic [8:0] STALL    = 9'b001_00_00_0_0;
    localparam logic [8:0] BUSY     = 9'b001_00_00_0_1;
    localparam logic [8:0] START    = 9'b110_00_00_1_0;
    localparam logic [8:0] RST_OUT  = 9'b111_00_00_0_0;

    task automatic clear_inputs();
        bus.id_rs = '0; bus.id_rt = '0; bus.id_rs_used = 0; bus.id_rt_used = 0;
        bus.id_is_muldiv = 0; bus.ex_rd = '0; bus.mem_rd = '0; bus.wb_rd = '0;
        bus.ex_regwrite = 0; bus.mem_regwrite = 0; bus.wb_regwrite = 0; bus.ex_load = 0;
    endtask

    task automatic ops(input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                       input logic rtu);
        bus.id_rs = rs; bus.id_rs_used = rsu; bus.id_rt = rt; bus.id_rt_used = rtu;
    endtask

    task automatic stages(input logic [4:0] erd, input logic ew, input logic eld,
                          input logic [4:0] mrd, input logic mw,
                          input logic [4:0] wrd, input logic ww);
        bus.ex_rd = erd; bus.ex_regwrite = ew; bus.ex_load = eld;
        bus.mem_rd = mrd; bus.mem_regwrite = mw; bus.wb_rd = wrd; bus.wb_regwrite = ww;
    endtask

    // Inputs are already driven just after a rising edge; sample mid-cycle, then advance.
    task automatic step(input string tag, input logic [8:0] expected);
        logic [8:0] obs;
        logic [8:0] want;
        string      t;
        exp_q.push_back(expected);
        tag_q.push_back(tag);
        #4;
        obs = {bus.pc_ld, bus.ifid_ld, bus.idex_bubble, bus.fwd_a, bus.fwd_b,
               bus.muldiv_start, bus.muldiv_busy};
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", t, obs, want);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        // Forwarding match and mult/div request are both masked while in reset.
        ops(5'd3, 1, 5'd0, 0);
        stages(5'd3, 1, 0, 5'd0, 0, 5'd0, 0);
        bus.id_is_muldiv = 1;
        step("reset_outputs", RST_OUT);
        step("reset_hold", RST_OUT);
        reset = 1'b0;
        clear_inputs();
        step("idle_run", RUN_IDLE);

        ops(5'd3, 1, 5'd2, 1);
        stages(5'd3, 1, 0, 5'd3, 1, 5'd0, 0);
        step("prio_ex_over_mem", ex(1, 1, 0, FWD_EX, FWD_RF, 0, 0));
        bus.ex_regwrite = 0;
        step("prio_mem", ex(1, 1, 0, FWD_MEM, FWD_RF, 0, 0));
        stages(5'd0, 0, 0, 5'd0, 0, 5'd3, 1);
        step("prio_wb", ex(1, 1, 0, FWD_WB, FWD_RF, 0, 0));
        bus.id_rs_used = 0;
        step("unused_operand", RUN_IDLE);
        ops(5'd0, 1, 5'd0, 0);
        stages(5'd0, 1, 0, 5'd0, 0, 5'd0, 0);
        step("zero_reg_no_match", RUN_IDLE);
        ops(5'd4, 1, 5'd5, 1);
        stages(5'd4, 1, 0, 5'd5, 1, 5'd4, 1);
        step("fwd_a_ex_fwd_b_mem", ex(1, 1, 0, FWD_EX, FWD_MEM, 0, 0));

        // Load-use on rt, then the load moves to MEM.
        ops(5'd1, 1, 5'd5, 1);
        stages(5'd5, 1, 1, 5'd0, 0, 5'd0, 0);
        step("load_use_stall", STALL);
        stages(5'd0, 0, 0, 5'd5, 1, 5'd0, 0);
        step("load_use_release", ex(1, 1, 0, FWD_RF, FWD_MEM, 0, 0));
        ops(5'd7, 0, 5'd0, 0);
        stages(5'd7, 1, 1, 5'd0, 0, 5'd0, 0);
        step("load_unused_no_stall", RUN_IDLE);

        // Single mult/div: one pulse, 7 held cycles, then RUN.
        clear_inputs();
        bus.id_is_muldiv = 1;
        step("muldiv_start", START);
        bus.id_is_muldiv = 0;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) begin
                ops(5'd8, 1, 5'd0, 0);
                stages(5'd0, 0, 0, 5'd0, 0, 5'd8, 1);
                step("busy_fwd_valid", ex(0, 0, 1, FWD_WB, FWD_RF, 0, 1));
                clear_inputs();
            end else begin
                step($sformatf("busy_%0d", i), BUSY);
            end
        end
        step("muldiv_done", RUN_IDLE);

        // Back-to-back: second mult/div held in ID; load-use ignored while busy.
        bus.id_is_muldiv = 1;
        step("b2b_first_start", START);
        ops(5'd0, 0, 5'd5, 1);
        stages(5'd5, 1, 1, 5'd0, 0, 5'd0, 0);
        for (int i = 0; i < 7; i++) step($sformatf("b2b_busy_%0d", i), BUSY);
        stages(5'd0, 0, 0, 5'd0, 0, 5'd0, 0);
        step("b2b_second_start", START);
        bus.id_is_muldiv = 0;
        for (int i = 0; i < 7; i++) step($sformatf("b2b2_busy_%0d", i), BUSY);
        step("b2b_done", RUN_IDLE);

        // Load-use beats mult/div; mult/div issues the cycle after.
        ops(5'd6, 1, 5'd0, 0);
        stages(5'd6, 1, 1, 5'd0, 0, 5'd0, 0);
        bus.id_is_muldiv = 1;
        step("simul_stall", STALL);
        stages(5'd0, 0, 0, 5'd6, 1, 5'd0, 0);
        step("simul_start", ex(1, 1, 0, FWD_MEM, FWD_RF, 1, 0));
        clear_inputs();
        for (int i = 0; i < 7; i++) step($sformatf("simul_busy_%0d", i), BUSY);
        step("simul_done", RUN_IDLE);

        // Reset while BUSY with cnt=4.
        bus.id_is_muldiv = 1;
        step("rst_busy_start", START);
        bus.id_is_muldiv = 0;
        for (int i = 0; i < 3; i++) step($sformatf("rst_busy_%0d", i), BUSY);
        reset = 1'b1;
        step("rst_mid_busy", RST_OUT);
        reset = 1'b0;
        step("rst_after_run", RUN_IDLE);
        step("rst_after_run2", RUN_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
